// File: rtl/jtag_config_deserializer.sv
// ----------------------------------------------------------------------------
// jtag_config_deserializer
//
// Collects TDI bits shifted while the CONFIG user instruction is selected and
// assembles them LSB-first into WORD_WIDTH-bit words for the eFPGA
// configuration port. Runs on the configuration clock (tck while JTAG owns
// the port).
//
// Optional feature macro: JTAG_CFG_CRC_EN
//   defined   -> CRC-32/MPEG-2 accumulator over every emitted word
//   undefined -> no CRC logic, crc_out tied to 0
//
// Ports
//   CLK             configuration clock
//   resetn          asynchronous active-low reset
//   cfg_sel         TAP instruction register holds CONFIG
//   shift_dr        TAP is in Shift-DR
//   update_dr       one-cycle Update-DR pulse
//   tdi             serial data in
//   tdo             bit shifted out of the assembly register (registered)
//   JTAGWriteData   last completed word, held until the next one
//   JTAGWriteStrobe one-cycle pulse per completed word
//   JTAGActive      JTAG owns the configuration port
//   word_count      words emitted this session, saturating
//   frag_error      sticky, set when a partial word is discarded
//   crc_out         running CRC of emitted words
// ----------------------------------------------------------------------------
module jtag_config_deserializer #(
    parameter int WORD_WIDTH  = 32,
    parameter int COUNT_WIDTH = 16
) (
    input  logic                   CLK,
    input  logic                   resetn,
    input  logic                   cfg_sel,
    input  logic                   shift_dr,
    input  logic                   update_dr,
    input  logic                   tdi,
    output logic                   tdo,
    output logic [WORD_WIDTH-1:0]  JTAGWriteData,
    output logic                   JTAGWriteStrobe,
    output logic                   JTAGActive,
    output logic [COUNT_WIDTH-1:0] word_count,
    output logic                   frag_error,
    output logic [31:0]            crc_out
);

    localparam int BitCntWidth = $clog2(WORD_WIDTH);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ARMED = 2'd1,
        SHIFT = 2'd2
    } state_t;

    state_t                  state;
    logic [WORD_WIDTH-1:0]   shReg;
    logic [BitCntWidth-1:0]  bitCnt;

    logic                    sessionOpen;
    logic                    lastBit;
    logic                    updDrop;
    logic                    shiftEn;
    logic                    wordDone;
    logic                    sessionStart;
    logic [WORD_WIDTH-1:0]   shNext;

    assign sessionOpen  = (state != IDLE);
    assign lastBit      = (bitCnt == BitCntWidth'(WORD_WIDTH - 1));
    // Update-DR only matters when it would throw away collected bits, and
    // then it wins over a simultaneous shift.
    assign updDrop      = update_dr && (bitCnt != '0);
    // With cfg_sel low, the only bit still accepted is the one that
    // completes a word.
    assign shiftEn      = sessionOpen && shift_dr && !updDrop && (cfg_sel || lastBit);
    assign wordDone     = shiftEn && lastBit;
    assign sessionStart = (state == IDLE) && cfg_sel;
    assign shNext       = {tdi, shReg[WORD_WIDTH-1:1]};

    always_ff @(posedge CLK or negedge resetn) begin
        if (!resetn) begin
            state           <= IDLE;
            shReg           <= '0;
            bitCnt          <= '0;
            tdo             <= 1'b0;
            JTAGWriteData   <= '0;
            JTAGWriteStrobe <= 1'b0;
            JTAGActive      <= 1'b0;
            word_count      <= '0;
            frag_error      <= 1'b0;
        end else begin
            JTAGWriteStrobe <= 1'b0;

            if (shiftEn) begin
                shReg  <= shNext;
                tdo    <= shReg[0];
                bitCnt <= lastBit ? '0 : bitCnt + BitCntWidth'(1);
                if (lastBit) begin
                    JTAGWriteData   <= shNext;
                    JTAGWriteStrobe <= 1'b1;
                    if (word_count != '1) begin
                        word_count <= word_count + COUNT_WIDTH'(1);
                    end
                end
            end

            case (state)
                IDLE: begin
                    if (cfg_sel) begin
                        state      <= ARMED;
                        JTAGActive <= 1'b1;
                        word_count <= '0;
                        frag_error <= 1'b0;
                        bitCnt     <= '0;
                    end else begin
                        JTAGActive <= 1'b0;
                    end
                end
                default: begin
                    if (!cfg_sel) begin
                        state      <= IDLE;
                        // A word completing on this edge keeps the port
                        // owned through its strobe cycle.
                        JTAGActive <= shiftEn;
                        bitCnt     <= '0;
                        if ((bitCnt != '0) && !shiftEn) begin
                            frag_error <= 1'b1;
                        end
                    end else begin
                        JTAGActive <= 1'b1;
                        state      <= shift_dr ? SHIFT : ARMED;
                        if (updDrop) begin
                            bitCnt     <= '0;
                            frag_error <= 1'b1;
                        end
                    end
                end
            endcase
        end
    end

`ifdef JTAG_CFG_CRC_EN
    localparam logic [31:0] CrcPoly = 32'h04C1_1DB7;
    localparam logic [31:0] CrcInit = 32'hFFFF_FFFF;

    logic [31:0] crcReg;

    // Whole word folded in one cycle, MSB first, no reflection.
    function automatic logic [31:0] crcStep(input logic [31:0] crcIn,
                                            input logic [WORD_WIDTH-1:0] data);
        logic [31:0] c;
        c = crcIn;
        for (int i = WORD_WIDTH - 1; i >= 0; i--) begin
            c = {c[30:0], 1'b0} ^ ((c[31] ^ data[i]) ? CrcPoly : 32'h0);
        end
        return c;
    endfunction

    always_ff @(posedge CLK or negedge resetn) begin
        if (!resetn) begin
            crcReg <= CrcInit;
        end else if (sessionStart) begin
            crcReg <= CrcInit;
        end else if (wordDone) begin
            crcReg <= crcStep(crcReg, shNext);
        end
    end

    assign crc_out = crcReg;
`else
    assign crc_out = '0;
`endif

endmodule

// File: tb/tb_jtag_config_deserializer.sv
`timescale 1ns/1ps
module tb_jtag_config_deserializer;

    localparam int W  = 32;
    localparam int CW = 16;
`ifdef JTAG_CFG_CRC_EN
    localparam logic [31:0] CRC_RST = 32'hFFFF_FFFF;
`else
    localparam logic [31:0] CRC_RST = 32'h0;
`endif

    logic          CLK = 1'b0;
    logic          resetn = 1'b0;
    logic          cfg_sel = 1'b0;
    logic          shift_dr = 1'b0;
    logic          update_dr = 1'b0;
    logic          tdi = 1'b0;
    logic          tdo;
    logic [W-1:0]  JTAGWriteData;
    logic          JTAGWriteStrobe;
    logic          JTAGActive;
    logic [CW-1:0] word_count;
    logic          frag_error;
    logic [31:0]   crc_out;

    jtag_config_deserializer #(.WORD_WIDTH(W), .COUNT_WIDTH(CW)) dut (
        .CLK            (CLK),
        .resetn         (resetn),
        .cfg_sel        (cfg_sel),
        .shift_dr       (shift_dr),
        .update_dr      (update_dr),
        .tdi            (tdi),
        .tdo            (tdo),
        .JTAGWriteData  (JTAGWriteData),
        .JTAGWriteStrobe(JTAGWriteStrobe),
        .JTAGActive     (JTAGActive),
        .word_count     (word_count),
        .frag_error     (frag_error),
        .crc_out        (crc_out)
    );

    always #5 CLK = ~CLK;

    int nVec = 0;
    int nErr = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        nVec++;
        if (act !== exp) begin
            nErr++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    bit           mOwn    = 0;
    bit           mActive = 0;
    bit           mStrobe = 0;
    bit           mFrag   = 0;
    bit           mTdo    = 0;
    logic [W-1:0] mData   = '0;
    int           mCount  = 0;
    logic [31:0]  mCrc    = CRC_RST;
    bit           mBits[$];   // bits of the word being collected, oldest first
    bit           mHist[$];   // last W bits shifted since reset

    // Byte-wise CRC-32/MPEG-2 over the word's bytes, most significant first.
    function automatic logic [31:0] crcModel(input logic [31:0] c, input logic [31:0] w);
        logic [31:0] r;
        r = c;
        for (int b = 3; b >= 0; b--) begin
            r = r ^ {w[8*b +: 8], 24'h0};
            for (int k = 0; k < 8; k++) begin
                r = r[31] ? ((r << 1) ^ 32'h04C1_1DB7) : (r << 1);
            end
        end
        return r;
    endfunction

    task automatic modelReset();
        mOwn = 0; mActive = 0; mStrobe = 0; mFrag = 0; mTdo = 0;
        mData = '0; mCount = 0; mCrc = CRC_RST;
        mBits.delete(); mHist.delete();
    endtask

    task automatic modelStep(input bit c, input bit s, input bit u, input bit d);
        bit discard, take;
        mStrobe = 0;
        if (!mOwn) begin
            if (c) begin
                mOwn = 1; mActive = 1; mCount = 0; mFrag = 0; mCrc = CRC_RST;
                mBits.delete();
            end else begin
                mActive = 0;
            end
        end else begin
            discard = u && (mBits.size() != 0);
            take    = s && !discard && (c || mBits.size() == W - 1);
            if (take) begin
                mTdo = (mHist.size() == W) ? mHist[0] : 1'b0;
                mHist.push_back(d);
                if (mHist.size() > W) void'(mHist.pop_front());
                mBits.push_back(d);
                if (mBits.size() == W) begin
                    for (int i = 0; i < W; i++) mData[i] = mBits[i];
                    mBits.delete();
                    mStrobe = 1;
                    if (mCount < (2 ** CW) - 1) mCount++;
`ifdef JTAG_CFG_CRC_EN
                    mCrc = crcModel(mCrc, mData);
`endif
                end
            end
            if (!c) begin
                mOwn = 0;
                mActive = take;
                if (mBits.size() != 0) mFrag = 1;
                mBits.delete();
            end else begin
                mActive = 1;
                if (discard) begin
                    mBits.delete();
                    mFrag = 1;
                end
            end
        end
    endtask

    always @(posedge CLK or negedge resetn) begin
        if (!resetn) modelReset();
        else modelStep(cfg_sel, shift_dr, update_dr, tdi);
    end

    // ---------------- per-cycle compare ----------------
    always @(negedge CLK) begin
        check("tdo", tdo, mTdo);
        check("data", JTAGWriteData, mData);
        check("strobe", JTAGWriteStrobe, mStrobe);
        check("active", JTAGActive, mActive);
        check("count", word_count, mCount);
        check("frag", frag_error, mFrag);
        check("crc", crc_out, mCrc);
    end

    // ---------------- strobe monitor ----------------
    int           cyc = 0;
    logic [W-1:0] sData[$];
    int           sCyc[$];
    always @(posedge CLK) cyc++;
    always @(negedge CLK) begin
        if (resetn && JTAGWriteStrobe) begin
            sData.push_back(JTAGWriteData);
            sCyc.push_back(cyc);
        end
    end

    // ---------------- stimulus ----------------
    task automatic drive(input bit c, input bit s, input bit u, input bit d);
        cfg_sel = c; shift_dr = s; update_dr = u; tdi = d;
        @(negedge CLK);
        #1;
    endtask

    task automatic shiftBits(input logic [31:0] w, input int n);
        for (int i = 0; i < n; i++) drive(1'b1, 1'b1, 1'b0, w[i]);
    endtask

    task automatic newSession();
        drive(1'b0, 1'b0, 1'b0, 1'b0);
        drive(1'b0, 1'b0, 1'b0, 1'b0);
        drive(1'b1, 1'b0, 1'b0, 1'b0);
        sData.delete();
        sCyc.delete();
    endtask

    initial begin
        logic [31:0] w;
        logic [31:0] crcExp;
        logic [7:0]  crcBytes [8];
        bit          c;

        repeat (2) @(negedge CLK);
        #1;
        check("reset_data", JTAGWriteData, 32'h0);
        check("reset_strobe", JTAGWriteStrobe, 1'b0);
        check("reset_active", JTAGActive, 1'b0);
        check("reset_count", word_count, 16'h0);
        check("reset_frag", frag_error, 1'b0);
        check("reset_tdo", tdo, 1'b0);
        check("reset_crc", crc_out, CRC_RST);
        resetn = 1'b1;

        // Single word
        drive(1'b0, 1'b0, 1'b0, 1'b0);
        check("single_active_pre", JTAGActive, 1'b0);
        drive(1'b1, 1'b0, 1'b0, 1'b0);
        check("single_active_rise", JTAGActive, 1'b1);
        sData.delete(); sCyc.delete();
        shiftBits(32'hFAB0_FAB1, 32);
        check("single_strobe", JTAGWriteStrobe, 1'b1);
        check("single_data", JTAGWriteData, 32'hFAB0_FAB1);
        check("single_count", word_count, 16'd1);
        drive(1'b1, 1'b0, 1'b0, 1'b0);
        check("single_strobe_width", JTAGWriteStrobe, 1'b0);
        check("single_nstrobes", sData.size(), 1);

        // Back-to-back burst
        newSession();
        shiftBits(32'h0000_0001, 32);
        shiftBits(32'h8000_0000, 32);
        shiftBits(32'hDEAD_BEEF, 32);
        drive(1'b1, 1'b0, 1'b0, 1'b0);
        check("burst_nstrobes", sData.size(), 3);
        if (sData.size() == 3) begin
            check("burst_w0", sData[0], 32'h0000_0001);
            check("burst_w1", sData[1], 32'h8000_0000);
            check("burst_w2", sData[2], 32'hDEAD_BEEF);
            check("burst_gap0", sCyc[1] - sCyc[0], 32);
            check("burst_gap1", sCyc[2] - sCyc[1], 32);
        end
        check("burst_count", word_count, 16'd3);

        // Fragment then full word
        newSession();
        shiftBits(32'h000A_5A5A, 20);
        drive(1'b1, 1'b0, 1'b1, 1'b0);
        check("frag_flag", frag_error, 1'b1);
        check("frag_nstrobes", sData.size(), 0);
        shiftBits(32'h1234_5678, 32);
        check("frag_next_strobe", JTAGWriteStrobe, 1'b1);
        check("frag_next_data", JTAGWriteData, 32'h1234_5678);
        check("frag_sticky", frag_error, 1'b1);

        // Session restart mid-word
        newSession();
        shiftBits(32'h0000_03FF, 10);
        check("restart_active_1", JTAGActive, 1'b1);
        drive(1'b0, 1'b0, 1'b0, 1'b0);
        check("restart_active_0", JTAGActive, 1'b0);
        check("restart_frag_set", frag_error, 1'b1);
        drive(1'b1, 1'b0, 1'b0, 1'b0);
        check("restart_active_1b", JTAGActive, 1'b1);
        check("restart_frag_clr", frag_error, 1'b0);
        check("restart_count_clr", word_count, 16'd0);
        check("restart_nstrobes", sData.size(), 0);

        // cfg_sel drops on the edge that samples the last bit
        newSession();
        w = 32'hA5A5_0F0F;
        shiftBits(w, 31);
        drive(1'b0, 1'b1, 1'b0, w[31]);
        check("lastbit_strobe", JTAGWriteStrobe, 1'b1);
        check("lastbit_data", JTAGWriteData, w);
        check("lastbit_active_hold", JTAGActive, 1'b1);
        drive(1'b0, 1'b0, 1'b0, 1'b0);
        check("lastbit_active_drop", JTAGActive, 1'b0);
        check("lastbit_frag", frag_error, 1'b0);

        // Asynchronous reset mid-word
        newSession();
        shiftBits(32'h0000_0155, 10);
        #2;
        resetn = 1'b0;
        #1;
        check("areset_data", JTAGWriteData, 32'h0);
        check("areset_active", JTAGActive, 1'b0);
        check("areset_count", word_count, 16'h0);
        check("areset_tdo", tdo, 1'b0);
        check("areset_crc", crc_out, CRC_RST);
        @(negedge CLK);
        #1;
        resetn = 1'b1;
        newSession();
        shiftBits(32'hC0FF_EE11, 32);
        check("areset_next_data", JTAGWriteData, 32'hC0FF_EE11);
        check("areset_next_count", word_count, 16'd1);
        check("areset_nstrobes", sData.size(), 1);

        // CRC over bytes 31..38
        newSession();
        shiftBits(32'h3132_3334, 32);
        shiftBits(32'h3536_3738, 32);
        drive(1'b1, 1'b0, 1'b0, 1'b0);
`ifdef JTAG_CFG_CRC_EN
        crcBytes = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38};
        crcExp = 32'hFFFF_FFFF;
        for (int b = 0; b < 8; b++) begin
            crcExp = crcExp ^ {crcBytes[b], 24'h0};
            for (int k = 0; k < 8; k++) begin
                crcExp = crcExp[31] ? ((crcExp << 1) ^ 32'h04C1_1DB7) : (crcExp << 1);
            end
        end
        check("crc_value", crc_out, crcExp);
`else
        crcBytes = '{default: 8'h0};
        crcExp = 32'h0;
        check("crc_off", crc_out, crcExp);
`endif

        // Randomised traffic checked every cycle by the model
        c = 1'b1;
        for (int n = 0; n < 4000; n++) begin
            if ($urandom_range(99) < 1) c = !c;
            drive(c, ($urandom_range(99) < 85), ($urandom_range(199) < 1), 1'($urandom_range(1)));
        end

        drive(1'b0, 1'b0, 1'b0, 1'b0);
        $display("== %0d vectors applied, %0d miscompares ==", nVec, nErr);
        $finish;
    end

endmodule
